// File: rtl/si4463_resp_pkg.sv
// Shared opcodes, FSM states and reply-buffer helper for the Si4463 SPI responder model.
package si4463_resp_pkg;

  localparam logic [7:0] CMD_READ_CMD_BUFF  = 8'h44;
  localparam logic [7:0] CMD_WRITE_TX_FIFO  = 8'h66;
  localparam logic [7:0] CMD_READ_RX_FIFO   = 8'h77;
  localparam logic [7:0] CMD_FIFO_INFO      = 8'h15;
  localparam logic [7:0] CMD_GET_INT_STATUS = 8'h20;
  localparam logic [7:0] CTS_READY          = 8'hFF;
  localparam int         REPLY_LEN          = 4;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    RESP_CTS,
    REPLY,
    TXFIFO,
    RXFIFO,
    IGNORE
  } state_t;

  typedef logic [0:REPLY_LEN-1][7:0] reply_t;

  // Reply buffer snapshot taken when a generic command's frame closes.
  function automatic reply_t reply_for(input logic [7:0] opcode,
                                       input logic [7:0] count_b,
                                       input logic [7:0] free_b,
                                       input logic       nirq);
    reply_t r;
    r = '0;
    case (opcode)
      CMD_FIFO_INFO: begin
        r[0] = count_b;
        r[1] = free_b;
      end
      CMD_GET_INT_STATUS: r[3] = nirq ? 8'h00 : 8'h20;
      default: r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/si4463_spi_responder_loop_fifo.sv
// Byte FIFO that loops TX-FIFO writes back to RX-FIFO reads; DEPTH must be a power of two.
module loop_fifo #(
  parameter int DEPTH = 64
) (
  input  logic                     clk,
  input  logic                     i_clear,
  input  logic                     i_push,
  input  logic [7:0]               i_push_data,
  input  logic                     i_pop,
  output logic [7:0]               o_rd_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          w_push_ok;
  logic          w_pop_ok;

  assign o_full    = (r_count == (AW+1)'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_rd_data = r_mem[r_rd_ptr];
  assign w_push_ok = i_push && !o_full;
  assign w_pop_ok  = i_pop && !o_empty;

  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= i_push_data;
  end

  always_ff @(posedge clk) begin
    if (i_clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_push_ok && !w_pop_ok)      r_count <= r_count + 1'b1;
      else if (w_pop_ok && !w_push_ok) r_count <= r_count - 1'b1;
    end
  end

endmodule

// File: rtl/si4463_spi_responder.sv
// Behavioural Si4463 SPI slave: CTS polling, TX->RX loop FIFO and nIRQ, oversampled on clk.
module si4463_spi_responder
  import si4463_resp_pkg::*;
#(
  parameter int FIFO_DEPTH = 64,
  parameter int CTS_DELAY  = 16,
  parameter int IRQ_DELAY  = 32
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        sdn,
  input  logic                        sclk,
  input  logic                        mosi,
  input  logic                        ss_n,
  output logic                        miso,
  output logic                        nirq,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        overflow,
  output logic                        underflow,
  output logic [2:0]                  o_dbg_state
);

  // SPI framing: ss_n low opens a frame, mode 0, MSB first. Each byte is
  // sampled on sclk rises; its response is loaded on the fall after the 8th rise.
  logic [2:0]  r_sclk_sy;
  logic [2:0]  r_ss_sy;
  logic [1:0]  r_mosi_sy;
  state_t      r_state;
  state_t      w_state_next;
  logic [2:0]  r_bit_cnt;
  logic [6:0]  r_rx_sr;
  logic [7:0]  r_tx_sr;
  logic [7:0]  r_resp_next;
  logic        r_load_pending;
  logic        r_cts_ok;
  logic        r_generic;
  logic [7:0]  r_opcode;
  logic [2:0]  r_reply_idx;
  reply_t      r_reply_buf;
  logic        r_cts;
  logic [15:0] r_cts_cnt;
  logic        r_irq_run;
  logic [15:0] r_irq_cnt;
  logic        r_nirq;
  logic        r_pushed;
  logic        r_overflow;
  logic        r_underflow;

  logic        w_rst;
  logic        w_sclk_rise;
  logic        w_sclk_fall;
  logic        w_ss_rise;
  logic        w_ss_fall;
  logic        w_byte_done;
  logic [7:0]  w_rx_byte;
  logic [7:0]  w_resp;
  logic        w_push;
  logic        w_pop;
  logic [7:0]  w_rd_data;
  logic        w_full;
  logic        w_empty;
  logic [$clog2(FIFO_DEPTH):0] w_count;
  logic        w_gen_done;

  assign w_rst       = reset | sdn;
  assign w_sclk_rise = r_sclk_sy[1] & ~r_sclk_sy[2];
  assign w_sclk_fall = ~r_sclk_sy[1] & r_sclk_sy[2];
  assign w_ss_rise   = r_ss_sy[1] & ~r_ss_sy[2];
  assign w_ss_fall   = ~r_ss_sy[1] & r_ss_sy[2];
  assign w_rx_byte   = {r_rx_sr, r_mosi_sy[1]};
  assign w_byte_done = w_sclk_rise && (r_bit_cnt == 3'd7) && (r_state != IDLE)
                       && !w_ss_rise && !w_ss_fall;
  assign w_gen_done  = w_ss_rise && (r_state == IGNORE) && r_generic;

  assign miso        = (r_state == IDLE) ? 1'b0 : r_tx_sr[7];
  assign nirq        = r_nirq;
  assign fifo_count  = w_count;
  assign overflow    = r_overflow;
  assign underflow   = r_underflow;
  assign o_dbg_state = r_state;

  loop_fifo #(.DEPTH(FIFO_DEPTH)) u_loop_fifo (
    .clk         (clk),
    .i_clear     (w_rst),
    .i_push      (w_push),
    .i_push_data (w_rx_byte),
    .i_pop       (w_pop),
    .o_rd_data   (w_rd_data),
    .o_full      (w_full),
    .o_empty     (w_empty),
    .o_count     (w_count)
  );

  always_comb begin
    w_state_next = r_state;
    w_push       = 1'b0;
    w_pop        = 1'b0;
    w_resp       = 8'h00;
    if (w_ss_fall) begin
      w_state_next = CMD;
    end else if (w_ss_rise) begin
      w_state_next = IDLE;
    end else if (w_byte_done) begin
      case (r_state)
        CMD: begin
          if (w_rx_byte == CMD_READ_CMD_BUFF) begin
            w_state_next = RESP_CTS;
            w_resp       = r_cts ? CTS_READY : 8'h00;
          end else if (w_rx_byte == CMD_WRITE_TX_FIFO) begin
            w_state_next = TXFIFO;
          end else if (w_rx_byte == CMD_READ_RX_FIFO) begin
            w_state_next = RXFIFO;
            w_pop        = 1'b1;
            w_resp       = w_empty ? 8'h00 : w_rd_data;
          end else begin
            w_state_next = IGNORE;
          end
        end
        RESP_CTS: begin
          if (r_cts_ok) begin
            w_state_next = REPLY;
            w_resp       = r_reply_buf[0];
          end else begin
            w_state_next = IGNORE;
          end
        end
        REPLY: begin
          if (r_reply_idx < 3'(REPLY_LEN)) w_resp = r_reply_buf[r_reply_idx[1:0]];
        end
        TXFIFO: w_push = 1'b1;
        RXFIFO: begin
          w_pop  = 1'b1;
          w_resp = w_empty ? 8'h00 : w_rd_data;
        end
        default: w_resp = 8'h00;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_rst) begin
      r_sclk_sy      <= 3'b000;
      r_ss_sy        <= 3'b111;
      r_mosi_sy      <= 2'b00;
      r_state        <= IDLE;
      r_bit_cnt      <= '0;
      r_rx_sr        <= '0;
      r_tx_sr        <= '0;
      r_resp_next    <= '0;
      r_load_pending <= 1'b0;
      r_cts_ok       <= 1'b0;
      r_generic      <= 1'b0;
      r_opcode       <= '0;
      r_reply_idx    <= '0;
      r_reply_buf    <= '0;
      r_cts          <= 1'b1;
      r_cts_cnt      <= '0;
      r_irq_run      <= 1'b0;
      r_irq_cnt      <= '0;
      r_nirq         <= 1'b1;
      r_pushed       <= 1'b0;
      r_overflow     <= 1'b0;
      r_underflow    <= 1'b0;
    end else begin
      r_sclk_sy <= {r_sclk_sy[1:0], sclk};
      r_ss_sy   <= {r_ss_sy[1:0], ss_n};
      r_mosi_sy <= {r_mosi_sy[0], mosi};
      r_state   <= w_state_next;

      if (w_ss_fall) begin
        r_bit_cnt      <= '0;
        r_rx_sr        <= '0;
        r_tx_sr        <= 8'h00;
        r_load_pending <= 1'b0;
        r_generic      <= 1'b0;
        r_pushed       <= 1'b0;
        r_reply_idx    <= '0;
      end else if (w_ss_rise) begin
        r_bit_cnt      <= '0;
        r_tx_sr        <= 8'h00;
        r_load_pending <= 1'b0;
      end else if (r_state != IDLE) begin
        if (w_sclk_rise) begin
          r_rx_sr   <= w_rx_byte[6:0];
          r_bit_cnt <= r_bit_cnt + 3'd1;
        end
        if (w_sclk_fall) begin
          if (r_load_pending) begin
            r_tx_sr        <= r_resp_next;
            r_load_pending <= 1'b0;
          end else begin
            r_tx_sr <= {r_tx_sr[6:0], 1'b0};
          end
        end
      end

      if (w_byte_done) begin
        r_resp_next    <= w_resp;
        r_load_pending <= 1'b1;
        if (r_state == CMD) begin
          if (w_rx_byte == CMD_READ_CMD_BUFF) begin
            r_cts_ok <= r_cts;
          end else if (w_rx_byte != CMD_WRITE_TX_FIFO && w_rx_byte != CMD_READ_RX_FIFO) begin
            r_opcode  <= w_rx_byte;
            r_generic <= 1'b1;
          end
        end
        if (r_state == RESP_CTS) r_reply_idx <= 3'd1;
        if (r_state == REPLY && r_reply_idx < 3'(REPLY_LEN)) r_reply_idx <= r_reply_idx + 3'd1;
      end

      if (w_push) begin
        if (w_full) r_overflow <= 1'b1;
        else        r_pushed   <= 1'b1;
      end
      if (w_pop && w_empty) r_underflow <= 1'b1;

      if (w_ss_rise && (r_state == TXFIFO) && r_pushed) begin
        r_irq_run <= 1'b1;
        r_irq_cnt <= 16'(IRQ_DELAY);
      end else if (r_irq_run) begin
        if (r_irq_cnt <= 16'd1) begin
          r_nirq    <= 1'b0;
          r_irq_run <= 1'b0;
          r_irq_cnt <= '0;
        end else begin
          r_irq_cnt <= r_irq_cnt - 16'd1;
        end
      end

      // The reply snapshot must see nirq before GET_INT_STATUS clears it.
      if (w_gen_done) begin
        r_cts       <= 1'b0;
        r_cts_cnt   <= 16'(CTS_DELAY);
        r_reply_buf <= reply_for(r_opcode, 8'(w_count), 8'(FIFO_DEPTH - int'(w_count)), r_nirq);
        if (r_opcode == CMD_GET_INT_STATUS) begin
          r_nirq    <= 1'b1;
          r_irq_run <= 1'b0;
        end
      end else if (!r_cts) begin
        if (r_cts_cnt <= 16'd1) begin
          r_cts     <= 1'b1;
          r_cts_cnt <= '0;
        end else begin
          r_cts_cnt <= r_cts_cnt - 16'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_si4463_spi_responder.sv
// Directed bench for si4463_spi_responder: SPI master driver, MISO byte scoreboard, status checks.
module tb_si4463_spi_responder;

  localparam int FIFO_DEPTH = 64;
  localparam int CTS_DELAY  = 200;
  localparam int IRQ_DELAY  = 32;
  localparam int HALF       = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic       sdn;
  logic       sclk;
  logic       mosi;
  logic       ss_n;
  logic       miso;
  logic       nirq;
  logic [6:0] fifo_count;
  logic       overflow;
  logic       underflow;
  logic [2:0] dbg_state;

  logic [7:0] exp_q[$];
  logic [7:0] data_tab[65];
  int         n_checks = 0;
  int         n_pass   = 0;
  int         mon_bits = 0;
  logic [7:0] mon_sr   = '0;
  int         irq_cycles;

  si4463_spi_responder #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .CTS_DELAY  (CTS_DELAY),
    .IRQ_DELAY  (IRQ_DELAY)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .sdn         (sdn),
    .sclk        (sclk),
    .mosi        (mosi),
    .ss_n        (ss_n),
    .miso        (miso),
    .nirq        (nirq),
    .fifo_count  (fifo_count),
    .overflow    (overflow),
    .underflow   (underflow),
    .o_dbg_state (dbg_state)
  );

  // Clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
  endtask

  // Driver tasks (inputs change on clk falling edges)
  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic ss_begin();
    ss_n = 1'b0;
    wait_clk(HALF);
  endtask

  task automatic ss_end();
    wait_clk(HALF);
    ss_n = 1'b1;
  endtask

  task automatic spi_bits(input logic [7:0] tx, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      mosi = tx[7-i];
      wait_clk(HALF);
      sclk = 1'b1;
      wait_clk(HALF);
      sclk = 1'b0;
    end
  endtask

  task automatic spi_byte(input logic [7:0] tx, input logic [7:0] exp);
    exp_q.push_back(exp);
    spi_bits(tx, 8);
  endtask

  task automatic wait_nirq_low(input int budget, output int n);
    n = 0;
    while (n < budget) begin
      @(posedge clk);
      #1;
      n++;
      if (!nirq) break;
    end
  endtask

  // Scoreboard monitor: master samples MISO on each sclk rise inside a frame
  always @(posedge sclk or negedge ss_n) begin
    if (sclk && !ss_n) begin
      mon_sr = {mon_sr[6:0], miso};
      mon_bits++;
      if (mon_bits == 8) begin
        mon_bits = 0;
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL miso_byte: got unexpected byte 0x%02h, required none", mon_sr);
        end else begin
          check("miso_byte", {24'h0, mon_sr}, {24'h0, exp_q.pop_front()});
        end
      end
    end else begin
      mon_bits = 0;
    end
  end

  initial begin
    reset = 1'b1;
    sdn   = 1'b0;
    sclk  = 1'b0;
    mosi  = 1'b0;
    ss_n  = 1'b1;
    for (int i = 0; i < 65; i++) data_tab[i] = 8'(i * 37 + 11);
    wait_clk(5);
    reset = 1'b0;
    wait_clk(2);
    check("rst_miso", {31'h0, miso}, 32'h0);
    check("rst_nirq", {31'h0, nirq}, 32'h1);
    check("rst_count", {25'h0, fifo_count}, 32'h0);
    check("rst_overflow", {31'h0, overflow}, 32'h0);
    check("rst_underflow", {31'h0, underflow}, 32'h0);

    // CTS poll straight after reset
    ss_begin();
    spi_byte(8'h44, 8'h00);
    spi_byte(8'h00, 8'hFF);
    spi_byte(8'h00, 8'h00);
    ss_end();
    wait_clk(6);
    check("poll_nirq", {31'h0, nirq}, 32'h1);
    check("idle_miso", {31'h0, miso}, 32'h0);

    // FIFO_INFO, immediate poll sees CTS low, later poll sees the reply
    ss_begin();
    spi_byte(8'h15, 8'h00);
    ss_end();
    wait_clk(4);
    ss_begin();
    spi_byte(8'h44, 8'h00);
    spi_byte(8'h00, 8'h00);
    spi_byte(8'h00, 8'h00);
    ss_end();
    wait_clk(CTS_DELAY + 3);
    ss_begin();
    spi_byte(8'h44, 8'h00);
    spi_byte(8'h00, 8'hFF);
    spi_byte(8'h00, 8'h00);
    spi_byte(8'h00, 8'h40);
    spi_byte(8'h00, 8'h00);
    ss_end();
    wait_clk(4);

    // TX write of three bytes, nIRQ timing, GET_INT_STATUS
    ss_begin();
    spi_byte(8'h66, 8'h00);
    spi_byte(8'hA5, 8'h00);
    spi_byte(8'h5A, 8'h00);
    spi_byte(8'h3C, 8'h00);
    ss_end();
    wait_nirq_low(IRQ_DELAY + 40, irq_cycles);
    check("irq_delay", irq_cycles, IRQ_DELAY + 3);
    check("tx_count", {25'h0, fifo_count}, 32'd3);
    wait_clk(2);
    ss_begin();
    spi_byte(8'h20, 8'h00);
    ss_end();
    wait_clk(6);
    check("int_clear_nirq", {31'h0, nirq}, 32'h1);
    wait_clk(CTS_DELAY + 10);
    ss_begin();
    spi_byte(8'h44, 8'h00);
    spi_byte(8'h00, 8'hFF);
    spi_byte(8'h00, 8'h00);
    spi_byte(8'h00, 8'h00);
    spi_byte(8'h00, 8'h00);
    spi_byte(8'h00, 8'h20);
    ss_end();
    wait_clk(4);

    // RX read drains the loop and runs one past empty
    ss_begin();
    spi_byte(8'h77, 8'h00);
    spi_byte(8'h00, 8'hA5);
    spi_byte(8'h00, 8'h5A);
    spi_byte(8'h00, 8'h3C);
    spi_byte(8'h00, 8'h00);
    ss_end();
    wait_clk(6);
    check("rx_underflow", {31'h0, underflow}, 32'h1);
    check("rx_count", {25'h0, fifo_count}, 32'h0);
    check("rx_no_overflow", {31'h0, overflow}, 32'h0);

    // Overfill with 65 bytes, then read back the first 64
    ss_begin();
    spi_byte(8'h66, 8'h00);
    for (int i = 0; i < 65; i++) spi_byte(data_tab[i], 8'h00);
    ss_end();
    wait_clk(6);
    check("full_count", {25'h0, fifo_count}, 32'd64);
    check("full_overflow", {31'h0, overflow}, 32'h1);
    ss_begin();
    spi_byte(8'h77, 8'h00);
    for (int i = 0; i < 64; i++) spi_byte(8'h00, data_tab[i]);
    ss_end();
    wait_clk(6);
    check("drain_count", {25'h0, fifo_count}, 32'h0);

    // Partial byte aborted by ss_n rise
    ss_begin();
    spi_byte(8'h66, 8'h00);
    spi_byte(8'h81, 8'h00);
    spi_bits(8'hFF, 5);
    ss_end();
    wait_clk(6);
    check("partial_count", {25'h0, fifo_count}, 32'd1);

    // sdn pulsed mid-transaction
    ss_begin();
    spi_byte(8'h66, 8'h00);
    spi_bits(8'hC3, 3);
    sdn = 1'b1;
    wait_clk(4);
    check("sdn_hold_nirq", {31'h0, nirq}, 32'h1);
    sdn = 1'b0;
    wait_clk(4);
    ss_end();
    wait_clk(IRQ_DELAY + 10);
    check("sdn_miso", {31'h0, miso}, 32'h0);
    check("sdn_nirq", {31'h0, nirq}, 32'h1);
    check("sdn_count", {25'h0, fifo_count}, 32'h0);
    check("sdn_overflow", {31'h0, overflow}, 32'h0);
    check("sdn_underflow", {31'h0, underflow}, 32'h0);

    check("exp_q_empty", exp_q.size(), 32'h0);

    // Final report
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/si4463_spi_responder.md
Name: si4463_spi_responder

Overview:
- Behavioural-grade SPI slave that acts as the Si4463 end of the radio SPI link: command byte, CTS polling, TX/RX FIFO access and nIRQ.
- Used in loopback builds and benches in place of the radio.
- Connects pin-for-pin to the SPI master's MOSI/MISO/SCLK/SS_n and to the si4463_irq/si4463_reset nets, so Wireless_Ctrl runs unmodified.
- Bytes written through WRITE_TX_FIFO are looped into a FIFO that READ_RX_FIFO drains.

Parameters:
- FIFO_DEPTH, 64, loop FIFO depth in bytes; power of two, 4..256.
- CTS_DELAY, 16, clk cycles from ss_n rise after a generic command until CTS becomes 1.
- IRQ_DELAY, 32, clk cycles from the end of a non-empty TX write until nirq falls.

Ports:
- clk  in  1  system clock; must be at least 8x sclk.
- reset  in  1  synchronous, active-high.
- sdn  in  1  radio shutdown/reset pin (si4463_reset); high holds the block in reset state.
- sclk  in  1  SPI clock, mode 0 (CPOL=0, CPHA=0), MSB first.
- mosi  in  1  SPI data in.
- ss_n  in  1  SPI select, active-low.
- miso  out  1  SPI data out.
- nirq  out  1  interrupt, active-low.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  loop FIFO occupancy.
- overflow  out  1  sticky: write attempted while FIFO full.
- underflow  out  1  sticky: read attempted while FIFO empty.

Behaviour:
- Reset (reset=1 or sdn=1), sampled on the clk edge:
  - state=IDLE, miso=0, nirq=1, fifo_count=0, overflow=0, underflow=0, cts=1, FIFO pointers cleared.
- Input synchronisation:
  - sclk, mosi and ss_n each pass through 2-flop synchronisers; edges are detected on the synchronised copies.
  - Latency from pin to internal event is 3 clk cycles.
- Framing:
  - ss_n fall: clear bit counter and byte index, enter CMD, load miso shift register with 0x00.
  - ss_n rise: abort any partial byte and return to IDLE. The FIFO keeps every byte completed before the rise.
- Bit timing:
  - On sclk rise: shift mosi in; the bit counter advances 0..7.
  - On the 8th rise: the byte is complete.
  - On each sclk fall: shift miso out. On the fall after the 8th rise, load the next response byte and drive its MSB immediately.
- CMD, first byte complete:
  - 0x44: go to RESP_CTS.
  - 0x66: go to TXFIFO.
  - 0x77: go to RXFIFO; pre-fetch the FIFO head for the next byte.
  - Any other value: latch the opcode and go to IGNORE.
- RESP_CTS:
  - Response byte 1 is 0xFF if cts=1, else 0x00.
  - If cts=0: go to IGNORE; later bytes return 0x00.
  - If cts=1: go to REPLY.
- REPLY:
  - Returns the reply buffer (4 bytes), then 0x00 for every further byte.
  - Reply buffer for last generic opcode 0x15 (FIFO_INFO): {fifo_count, FIFO_DEPTH-fifo_count, 0x00, 0x00}.
  - Reply buffer for 0x20 (GET_INT_STATUS): {0x00, 0x00, 0x00, nirq ? 0x00 : 0x20}.
  - Any other opcode: all zeros.
- TXFIFO: each completed byte is pushed. If full: drop it, set overflow, fifo_count unchanged.
- RXFIFO:
  - Each completed byte pops the head; the popped value is the response for the byte that follows.
  - If empty: respond 0x00 and set underflow.
- Concurrency: push and pop cannot occur in the same cycle; a single transaction has one direction.
- Generic command completion (ss_n rise after a complete byte in IGNORE):
  - cts=0, load the CTS counter with CTS_DELAY.
  - When the counter reaches 0, cts=1.
  - A new generic command while cts=0 reloads the counter.
- 0x20 completion: nirq returns to 1 at its ss_n rise. If an IRQ_DELAY countdown is running, it is cancelled.
- nirq assertion: ss_n rise ending a 0x66 transaction that pushed at least 1 byte starts the IRQ_DELAY countdown; at 0, nirq=0. nirq stays 0 until cleared by 0x20.
- Idle output: miso=0 while ss_n high.

Decomposition:
- Package si4463_resp_pkg holds:
  - opcodes CMD_READ_CMD_BUFF=0x44, CMD_WRITE_TX_FIFO=0x66, CMD_READ_RX_FIFO=0x77, CMD_FIFO_INFO=0x15, CMD_GET_INT_STATUS=0x20;
  - CTS_READY=0xFF;
  - state enum {IDLE, CMD, RESP_CTS, REPLY, TXFIFO, RXFIFO, IGNORE};
  - reply length constant 4.
- One sub-module, loop_fifo: synchronous byte FIFO with push/pop, full/empty, count and synchronous active-high clear.

Test Plan:
- After reset, 0x44 then 2 dummy bytes -> MISO bytes 0x00, 0xFF, 0x00; nirq=1.
- 0x15 then an immediate 0x44 poll -> 0x00 returned for CTS. Polling after CTS_DELAY+3 cycles -> 0xFF, then 0x00, 0x40 (empty FIFO, FIFO_DEPTH=64).
- 0x66 with 0xA5, 0x5A, 0x3C -> fifo_count=3. nirq falls IRQ_DELAY cycles after ss_n rise. A 0x20 transaction -> 4th reply byte 0x20, then nirq=1.
- 0x77 then 4 dummy bytes after that write -> MISO 0x00, 0xA5, 0x5A, 0x3C, 0x00; underflow=1; fifo_count=0.
- 65 bytes written via 0x66 -> fifo_count=64, overflow=1. The first 64 bytes read back intact.
- ss_n raised after 5 bits of a TX data byte, then sdn pulsed mid-transaction -> the partial byte is discarded. After sdn, all outputs are at reset values and fifo_count=0.
